// File: rtl/ex_me_pipe.sv
// EX->MEM pipeline register with valid/ready handshake.
// SKID=0 builds a single entry whose in_ready is combinational. SKID=1 builds
// a main entry plus a skid entry, so in_ready comes straight from a flop.
// The module also counts the cycles in which MEM back-pressures a valid payload.
module ex_me_pipe #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  incrementPCIn,
    input  logic [XLEN-1:0]  ALUResIn,
    input  logic [XLEN-1:0]  RS2In,
    input  logic [RD_W-1:0]  rdIn,
    input  logic             dm_writeIn,
    input  logic [2:0]       dm_ctrlIn,
    input  logic [1:0]       ru_data_srcIn,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  incrementPCOut,
    output logic [XLEN-1:0]  ALUResOut,
    output logic [XLEN-1:0]  RS2Out,
    output logic [RD_W-1:0]  rdOut,
    output logic             dm_writeOut,
    output logic [2:0]       dm_ctrlOut,
    output logic [1:0]       ru_data_srcOut,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int PW = 3 * XLEN + RD_W + 6;

    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    main_q;
    logic             main_valid_q;
    logic             dm_write_stored;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign in_payload = {incrementPCIn, ALUResIn, RS2In, rdIn,
                         dm_writeIn, dm_ctrlIn, ru_data_srcIn};

    generate
        if (SKID == 0) begin : g_single
            logic [PW-1:0] main_d;
            logic          main_valid_d;
            logic          take_in;

            // An empty entry, or one that is draining this cycle, can accept new data.
            assign in_ready = !main_valid_q || out_ready;
            assign take_in  = in_valid && in_ready && !flush;

            // Next-state logic: a flush wins, then a load (which also replaces a draining entry), then a drain.
            always_comb begin
                main_d       = main_q;
                main_valid_d = main_valid_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                end else if (take_in) begin
                    main_d       = in_payload;
                    main_valid_d = 1'b1;
                end else if (main_valid_q && out_ready) begin
                    main_valid_d = 1'b0;
                end
            end

            // Entry register. The payload is kept when the entry is invalidated so that outputs hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q       <= '0;
                    main_valid_q <= 1'b0;
                end else begin
                    main_q       <= main_d;
                    main_valid_q <= main_valid_d;
                end
            end
        end else begin : g_skid
            logic [PW-1:0] main_d;
            logic [PW-1:0] skid_q;
            logic [PW-1:0] skid_d;
            logic          main_valid_d;
            logic          skid_valid_q;
            logic          skid_valid_d;
            logic          take_in;

            // The skid entry is only occupied while main is stalled, so its flop gates input.
            assign in_ready = !skid_valid_q;
            assign take_in  = in_valid && !skid_valid_q && !flush;

            // Next-state logic: skid data takes priority when main drains, to keep FIFO order.
            always_comb begin
                main_d       = main_q;
                main_valid_d = main_valid_q;
                skid_d       = skid_q;
                skid_valid_d = skid_valid_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end else if (!main_valid_q) begin
                    if (take_in) begin
                        main_d       = in_payload;
                        main_valid_d = 1'b1;
                    end
                end else if (out_ready) begin
                    if (skid_valid_q) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end else if (take_in) begin
                        main_d = in_payload;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end else if (take_in) begin
                    skid_d       = in_payload;
                    skid_valid_d = 1'b1;
                end
            end

            // Main and skid registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q       <= '0;
                    main_valid_q <= 1'b0;
                    skid_q       <= '0;
                    skid_valid_q <= 1'b0;
                end else begin
                    main_q       <= main_d;
                    main_valid_q <= main_valid_d;
                    skid_q       <= skid_d;
                    skid_valid_q <= skid_valid_d;
                end
            end
        end
    endgenerate

    assign {incrementPCOut, ALUResOut, RS2Out, rdOut,
            dm_write_stored, dm_ctrlOut, ru_data_srcOut} = main_q;
    assign out_valid   = main_valid_q;
    // Gate the store enable so that a bubble can never write data memory.
    assign dm_writeOut = dm_write_stored && main_valid_q;
    assign stall_cnt   = stall_cnt_q;

    // Count cycles with a valid payload blocked by MEM. The count saturates and a flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_me_pipe.sv
// Directed table-driven bench for ex_me_pipe. It instantiates two DUTs:
// dut_a uses SKID=1 with CNT_W=16, and dut_b uses SKID=0 with CNT_W=4 so that
// stall counter saturation is reached quickly.
// Each payload field is derived from a 32-bit tag: PC=tag+4, ALU=tag, RS2=~tag,
// rd=tag[4:0], dm_ctrl=tag[2:0] and ru_src=tag[1:0].
module tb_ex_me_pipe;

    typedef struct {
        bit          iv;
        bit          ordy;
        bit          fl;
        bit          dmw;
        logic [31:0] tag;
        bit          e_ir;
        bit          e_ov;
        bit          e_dmw;
        logic [31:0] e_tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Signals for dut_a (SKID=1).
    logic        a_iv = 1'b0, a_or = 1'b0, a_fl = 1'b0, a_dmw = 1'b0;
    logic [31:0] a_tag = '0;
    logic        a_ir, a_ov, a_dmw_o;
    logic [31:0] a_pc_o, a_alu_o, a_rs2_o;
    logic [4:0]  a_rd_o;
    logic [2:0]  a_ctrl_o;
    logic [1:0]  a_src_o;
    logic [15:0] a_stall;

    // Signals for dut_b (SKID=0).
    logic        b_iv = 1'b0, b_or = 1'b0, b_fl = 1'b0, b_dmw = 1'b0;
    logic [31:0] b_tag = '0;
    logic        b_ir, b_ov, b_dmw_o;
    logic [31:0] b_pc_o, b_alu_o, b_rs2_o;
    logic [4:0]  b_rd_o;
    logic [2:0]  b_ctrl_o;
    logic [1:0]  b_src_o;
    logic [3:0]  b_stall;

    ex_me_pipe #(.XLEN(32), .RD_W(5), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
        .incrementPCIn(a_tag + 32'd4), .ALUResIn(a_tag), .RS2In(~a_tag),
        .rdIn(a_tag[4:0]), .dm_writeIn(a_dmw), .dm_ctrlIn(a_tag[2:0]),
        .ru_data_srcIn(a_tag[1:0]), .flush(a_fl), .out_valid(a_ov),
        .out_ready(a_or), .incrementPCOut(a_pc_o), .ALUResOut(a_alu_o),
        .RS2Out(a_rs2_o), .rdOut(a_rd_o), .dm_writeOut(a_dmw_o),
        .dm_ctrlOut(a_ctrl_o), .ru_data_srcOut(a_src_o), .stall_cnt(a_stall)
    );

    ex_me_pipe #(.XLEN(32), .RD_W(5), .SKID(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
        .incrementPCIn(b_tag + 32'd4), .ALUResIn(b_tag), .RS2In(~b_tag),
        .rdIn(b_tag[4:0]), .dm_writeIn(b_dmw), .dm_ctrlIn(b_tag[2:0]),
        .ru_data_srcIn(b_tag[1:0]), .flush(b_fl), .out_valid(b_ov),
        .out_ready(b_or), .incrementPCOut(b_pc_o), .ALUResOut(b_alu_o),
        .RS2Out(b_rs2_o), .rdOut(b_rd_o), .dm_writeOut(b_dmw_o),
        .dm_ctrlOut(b_ctrl_o), .ru_data_srcOut(b_src_o), .stall_cnt(b_stall)
    );

    int n_pass = 0;
    int n_total = 0;
    bit a_prev_ov = 1'b0;
    bit b_prev_ov = 1'b0;
    int a_model = 0;
    int b_model = 0;
    vec_t ta[$];
    vec_t tb[$];

    function automatic vec_t mk(bit iv, bit ordy, bit fl, bit dmw, logic [31:0] tag,
                                bit e_ir, bit e_ov, bit e_dmw, logic [31:0] e_tag);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.dmw = dmw; v.tag = tag;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_dmw = e_dmw; v.e_tag = e_tag;
        return v;
    endfunction

    function automatic logic [73:0] fields(logic [31:0] t);
        logic [31:0] pc;
        pc = t + 32'd4;
        return {pc, ~t, t[4:0], t[2:0], t[1:0]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    // Apply one table row to the selected DUT (0 = a, 1 = b).
    task automatic step(input bit sel, input vec_t v, input int idx);
        @(negedge clk);
        if (!sel) begin
            a_iv = v.iv; a_or = v.ordy; a_fl = v.fl; a_dmw = v.dmw; a_tag = v.tag;
        end else begin
            b_iv = v.iv; b_or = v.ordy; b_fl = v.fl; b_dmw = v.dmw; b_tag = v.tag;
        end
        #1;
        if (!sel) begin
            chk($sformatf("a_in_ready[%0d]", idx), a_ir, v.e_ir);
            if (a_prev_ov && !v.ordy && a_model < 65535) a_model++;
        end else begin
            chk($sformatf("b_in_ready[%0d]", idx), b_ir, v.e_ir);
            if (b_prev_ov && !v.ordy && b_model < 15) b_model++;
        end
        @(posedge clk);
        #1;
        if (!sel) begin
            chk($sformatf("a_out_valid[%0d]", idx), a_ov, v.e_ov);
            chk($sformatf("a_alu[%0d]", idx), a_alu_o, v.e_tag);
            chk($sformatf("a_dm_write[%0d]", idx), a_dmw_o, v.e_dmw);
            chk($sformatf("a_payload[%0d]", idx),
                {a_pc_o, a_rs2_o, a_rd_o, a_ctrl_o, a_src_o}, fields(v.e_tag));
            chk($sformatf("a_stall[%0d]", idx), a_stall, a_model);
            a_prev_ov = v.e_ov;
        end else begin
            chk($sformatf("b_out_valid[%0d]", idx), b_ov, v.e_ov);
            chk($sformatf("b_alu[%0d]", idx), b_alu_o, v.e_tag);
            chk($sformatf("b_dm_write[%0d]", idx), b_dmw_o, v.e_dmw);
            chk($sformatf("b_payload[%0d]", idx),
                {b_pc_o, b_rs2_o, b_rd_o, b_ctrl_o, b_src_o}, fields(v.e_tag));
            chk($sformatf("b_stall[%0d]", idx), b_stall, b_model);
            b_prev_ov = v.e_ov;
        end
    endtask

    initial begin
        // Table for the SKID=1 DUT. Columns: iv or fl dmw tag | exp: in_ready out_valid dm_write alu_tag.
        for (int k = 1; k <= 8; k++) ta.push_back(mk(1, 1, 0, 0, k, 1, 1, 0, k));
        ta.push_back(mk(0, 1, 0, 0, 0,     1, 0, 0, 8));
        ta.push_back(mk(1, 0, 0, 1, 'h10,  1, 1, 1, 'h10));
        ta.push_back(mk(1, 0, 0, 0, 'h20,  1, 1, 1, 'h10));
        ta.push_back(mk(1, 0, 0, 0, 'h30,  0, 1, 1, 'h10));
        ta.push_back(mk(1, 1, 0, 0, 'h30,  0, 1, 0, 'h20));
        ta.push_back(mk(1, 1, 0, 0, 'h30,  1, 1, 0, 'h30));
        ta.push_back(mk(0, 1, 0, 0, 0,     1, 0, 0, 'h30));
        ta.push_back(mk(1, 0, 0, 1, 'h40,  1, 1, 1, 'h40));
        ta.push_back(mk(1, 0, 0, 1, 'h41,  1, 1, 1, 'h40));
        ta.push_back(mk(1, 0, 1, 1, 'h42,  0, 0, 0, 'h40));
        ta.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0, 'h40));
        ta.push_back(mk(0, 1, 0, 0, 0,     1, 0, 0, 'h40));
        ta.push_back(mk(1, 1, 1, 1, 'h50,  1, 0, 0, 'h40));
        ta.push_back(mk(0, 1, 0, 0, 0,     1, 0, 0, 'h40));

        // Table for the SKID=0 DUT.
        tb.push_back(mk(1, 0, 0, 0, 1,     1, 1, 0, 1));
        tb.push_back(mk(1, 0, 0, 0, 2,     0, 1, 0, 1));
        tb.push_back(mk(1, 1, 0, 0, 2,     1, 1, 0, 2));
        tb.push_back(mk(1, 1, 0, 0, 3,     1, 1, 0, 3));
        tb.push_back(mk(0, 1, 0, 0, 0,     1, 0, 0, 3));
        tb.push_back(mk(1, 0, 0, 1, 4,     1, 1, 1, 4));
        tb.push_back(mk(1, 0, 1, 1, 5,     0, 0, 0, 4));
        tb.push_back(mk(1, 1, 1, 1, 6,     1, 0, 0, 4));
        tb.push_back(mk(1, 0, 0, 0, 7,     1, 1, 0, 7));
        for (int k = 0; k < 20; k++) tb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 7));
        tb.push_back(mk(0, 1, 0, 0, 0,     1, 0, 0, 7));

        // Check the reset state before any clock edge, while reset is held.
        #1;
        chk("rst_a_out_valid", a_ov, 1'b0);
        chk("rst_a_in_ready", a_ir, 1'b1);
        chk("rst_a_payload", {a_pc_o, a_alu_o, a_rs2_o, a_rd_o, a_dmw_o, a_ctrl_o, a_src_o}, '0);
        chk("rst_a_stall", a_stall, 16'd0);
        chk("rst_b_out_valid", b_ov, 1'b0);
        chk("rst_b_in_ready", b_ir, 1'b1);
        chk("rst_b_stall", b_stall, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_a_out_valid", a_ov, 1'b0);
        chk("post_rst_b_out_valid", b_ov, 1'b0);

        foreach (ta[i]) step(1'b0, ta[i], i);
        foreach (tb[i]) step(1'b1, tb[i], i);

        // Fill main and skid on dut_a, then assert reset between clock edges.
        step(1'b0, mk(1, 0, 0, 1, 'h60, 1, 1, 1, 'h60), 100);
        step(1'b0, mk(1, 0, 0, 1, 'h61, 1, 1, 1, 'h60), 101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a_out_valid", a_ov, 1'b0);
        chk("async_rst_a_dm_write", a_dmw_o, 1'b0);
        chk("async_rst_a_payload", {a_pc_o, a_alu_o, a_rs2_o, a_rd_o, a_ctrl_o, a_src_o}, '0);
        chk("async_rst_a_in_ready", a_ir, 1'b1);
        chk("async_rst_a_stall", a_stall, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_iv = 1'b0;
        a_or = 1'b1;
        @(posedge clk); #1;
        chk("rel_a_out_valid", a_ov, 1'b0);
        chk("rel_a_alu", a_alu_o, 32'd0);
        @(posedge clk); #1;
        chk("rel2_a_out_valid", a_ov, 1'b0);
        chk("rel2_a_in_ready", a_ir, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
